// File: rtl/number_gen.sv
// number_gen: sequence generator for the memory game.
// Produces a run of pseudo-random, nonzero 10-bit patterns. Each pattern is
// written once into the number memory and then shown on the display for a
// fixed time, followed by a blank gap. done flags the end of the run.

module number_gen #(
  parameter int          SLOTS       = 10,
  parameter int          SHOW_CYCLES = 25000000,
  parameter int          GAP_CYCLES  = 12500000,
  parameter logic [9:0]  SEED        = 10'h2A5
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       start,
  input  logic [3:0] count,
  output logic [3:0] wn,
  output logic [9:0] d,
  output logic       we,
  output logic [9:0] num,
  output logic       show,
  output logic       busy,
  output logic       done
);

  // The timer only has to reach the longer of the two phase lengths minus one.
  localparam int MAX_CYCLES = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
  localparam logic [3:0]    SLOTS_W   = 4'(SLOTS);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [9:0]    SEED_EFF  = (SEED == 10'h000) ? 10'h001 : SEED;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    SHOW,
    GAP
  } state_t;

  state_t        state, state_n;
  logic [9:0]    lfsr;
  logic [3:0]    cnt, cnt_n;
  logic [3:0]    idx, idx_n;
  logic [9:0]    prev, prev_n;
  logic [TW-1:0] timer, timer_n;
  logic [3:0]    wn_n;
  logic [9:0]    d_n;
  logic          we_n;
  logic [9:0]    num_n;
  logic          show_n;
  logic          busy_n;
  logic          done_n;
  logic [3:0]    count_clamped;

  // A requested length of zero or beyond the memory size means a full run.
  assign count_clamped = ((count == 4'd0) || (count > SLOTS_W)) ? SLOTS_W : count;

  // Free-running LFSR; it keeps stepping in every state so player timing
  // changes which patterns a run draws.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      lfsr <= SEED_EFF;
    end else begin
      lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
    end
  end

  // State, run bookkeeping and all outputs are registered here.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
      cnt   <= 4'd0;
      idx   <= 4'd0;
      prev  <= 10'd0;
      timer <= '0;
      wn    <= 4'd0;
      d     <= 10'd0;
      we    <= 1'b0;
      num   <= 10'd0;
      show  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      prev  <= prev_n;
      timer <= timer_n;
      wn    <= wn_n;
      d     <= d_n;
      we    <= we_n;
      num   <= num_n;
      show  <= show_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  // Next-state and next-output logic; a write is skipped for one cycle when
  // the LFSR happens to match the previous pattern so neighbours always differ.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    prev_n  = prev;
    timer_n = timer;
    wn_n    = wn;
    d_n     = d;
    we_n    = 1'b0;
    num_n   = num;
    show_n  = show;
    done_n  = done;

    case (state)
      IDLE: begin
        if (start) begin
          cnt_n   = count_clamped;
          idx_n   = 4'd0;
          done_n  = 1'b0;
          prev_n  = 10'd0;
          state_n = WRITE;
        end
      end

      WRITE: begin
        if (lfsr != prev) begin
          we_n    = 1'b1;
          wn_n    = idx;
          d_n     = lfsr;
          num_n   = lfsr;
          show_n  = 1'b1;
          prev_n  = lfsr;
          timer_n = '0;
          state_n = SHOW;
        end
      end

      SHOW: begin
        if (timer == SHOW_LAST) begin
          num_n   = 10'd0;
          show_n  = 1'b0;
          timer_n = '0;
          state_n = GAP;
        end else begin
          timer_n = timer + TW'(1);
        end
      end

      GAP: begin
        if (timer == GAP_LAST) begin
          timer_n = '0;
          if ((idx + 4'd1) == cnt) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            idx_n   = idx + 4'd1;
            state_n = WRITE;
          end
        end else begin
          timer_n = timer + TW'(1);
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_number_gen.sv
// tb_number_gen: randomized self-checking bench for number_gen.
// A free-running LFSR model predicts every written pattern; run length,
// display/gap timing, done/busy and reset behaviour are checked from the
// externally visible events of each run.

module tb_number_gen;

  localparam int SHOW = 4;
  localparam int GAP  = 2;

  logic       clk;
  logic       clrn;
  logic       start;
  logic [3:0] count;
  logic [3:0] wn;
  logic [9:0] d;
  logic       we;
  logic [9:0] num;
  logic       show;
  logic       busy;
  logic       done;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [9:0] mLfsr;
  logic [9:0] preLfsr;
  logic [9:0] dupVal;
  logic [9:0] firstD;
  bit         aborted;

  number_gen #(
    .SLOTS       (10),
    .SHOW_CYCLES (SHOW),
    .GAP_CYCLES  (GAP),
    .SEED        (10'h001)
  ) dut (
    .clk   (clk),
    .clrn  (clrn),
    .start (start),
    .count (count),
    .wn    (wn),
    .d     (d),
    .we    (we),
    .num   (num),
    .show  (show),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] lfsrStep(input logic [9:0] v);
    return {v[8:0], v[9] ^ v[6]};
  endfunction

  // Reference LFSR: steps on every edge out of reset; preLfsr is the value
  // that was current just before the latest edge.
  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      mLfsr   <= 10'h001;
      preLfsr <= 10'h000;
    end else begin
      preLfsr <= mLfsr;
      mLfsr   <= lfsrStep(mLfsr);
    end
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_wn"},   int'(wn),   0);
    checkOutput({tag, "_d"},    int'(d),    0);
    checkOutput({tag, "_we"},   int'(we),   0);
    checkOutput({tag, "_num"},  int'(num),  0);
    checkOutput({tag, "_show"}, int'(show), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_done"}, int'(done), 0);
  endtask

  // Presents a start request; called away from the rising edge, returns 1
  // time unit after the edge that sampled it.
  task automatic applyStimulus(input logic [3:0] c, input bit hold);
    start = 1'b1;
    count = c;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Follows one run from the edge after the start was sampled until done.
  task automatic trackRun(input int expN, input int pokeAt, input int abortAfter,
                          input logic [9:0] expFirstD,
                          output logic [9:0] gotFirstD, output bit wasAborted);
    int         writes   = 0;
    int         showRun  = 0;
    int         lowRun   = 0;
    int         iter     = 0;
    bit         finished = 0;
    bit         poking   = 0;
    logic       prevShow = 1'b0;
    logic       prevWe   = 1'b0;
    logic [9:0] lastD    = 10'd0;
    gotFirstD  = 10'd0;
    wasAborted = 0;
    while (!finished && iter < 300) begin
      @(posedge clk);
      #1;
      iter++;
      if (poking) begin
        start  = 1'b0;
        poking = 0;
      end
      if (we) begin
        checkOutput("we_single", int'(prevWe), 0);
        checkOutput("wn_order", int'(wn), writes);
        checkOutput("d_model", int'(d), int'(preLfsr));
        checkOutput("d_nonzero", int'(d != 10'd0), 1);
        checkOutput("num_shown", int'(num), int'(preLfsr));
        checkOutput("show_on", int'(show), 1);
        checkOutput("busy_run", int'(busy), 1);
        if (writes == 0) begin
          checkOutput("first_latency", iter, 1);
          gotFirstD = d;
          if (expFirstD != 10'd0) checkOutput("first_d", int'(d), int'(expFirstD));
        end else begin
          checkOutput("d_differs", int'(d != lastD), 1);
          checkOutput("blank_len", lowRun, GAP + 1);
        end
        lastD = d;
        writes++;
        showRun = 0;
      end
      if (show) begin
        showRun++;
      end else if (prevShow) begin
        checkOutput("show_len", showRun, SHOW);
        checkOutput("num_blank", int'(num), 0);
        lowRun = 1;
      end else begin
        lowRun++;
      end
      if (pokeAt > 0 && writes == pokeAt && show && showRun == 2) begin
        start  = 1'b1;
        count  = 4'd1;
        poking = 1;
      end
      if (abortAfter > 0 && writes == abortAfter && !show && lowRun == 1) begin
        wasAborted = 1;
        finished   = 1;
      end else if (done) begin
        checkOutput("write_count", writes, expN);
        checkOutput("busy_idle", int'(busy), 0);
        checkOutput("final_gap", lowRun, GAP + 1);
        finished = 1;
      end
      prevShow = show;
      prevWe   = we;
    end
    if (!finished) checkOutput("run_timeout", 0, 1);
  endtask

  initial begin
    clrn  = 1'b0;
    start = 1'b0;
    count = 4'd0;
    #3;
    checkResetOutputs("reset");

    // Basic run: start sampled on the first edge after release.
    @(negedge clk);
    clrn = 1'b1;
    applyStimulus(4'd3, 0);
    trackRun(3, 0, 0, 10'h002, firstD, aborted);

    // Clamped lengths, started after a random idle time.
    repeat ($urandom_range(1, 9)) @(negedge clk);
    applyStimulus(4'd0, 0);
    trackRun(10, 0, 0, 10'h000, firstD, aborted);
    repeat ($urandom_range(1, 9)) @(negedge clk);
    applyStimulus(4'd15, 0);
    trackRun(10, 0, 0, 10'h000, firstD, aborted);

    // A start pulse in the middle of SHOW is ignored.
    repeat ($urandom_range(1, 9)) @(negedge clk);
    applyStimulus(4'($urandom_range(3, 9)), 0);
    trackRun(int'(count), 2, 0, 10'h000, firstD, aborted);

    // Reset during the gap of entry 2 clears everything without an edge.
    repeat ($urandom_range(1, 9)) @(negedge clk);
    applyStimulus(4'd5, 0);
    trackRun(5, 0, 3, 10'h000, firstD, aborted);
    checkOutput("abort_reached", int'(aborted), 1);
    #2;
    clrn = 1'b0;
    #1;
    checkResetOutputs("midrun");
    @(negedge clk);
    clrn = 1'b1;
    applyStimulus(4'd3, 0);
    trackRun(3, 0, 0, 10'h002, firstD, aborted);

    // Duplicate suppression: prev forced to the upcoming candidate.
    repeat ($urandom_range(1, 9)) @(negedge clk);
    applyStimulus(4'd2, 0);
    dupVal = mLfsr;
    force dut.prev = dupVal;
    @(posedge clk);
    #1;
    checkOutput("dup_stall_we", int'(we), 0);
    checkOutput("dup_stall_busy", int'(busy), 1);
    release dut.prev;
    trackRun(2, 0, 0, 10'h000, firstD, aborted);
    checkOutput("dup_differs", int'(firstD != dupVal), 1);

    // Back-to-back runs with start held high.
    repeat ($urandom_range(1, 9)) @(negedge clk);
    applyStimulus(4'd2, 1);
    trackRun(2, 0, 0, 10'h000, firstD, aborted);
    checkOutput("b2b_done_high", int'(done), 1);
    @(posedge clk);
    #1;
    checkOutput("b2b_done_clear", int'(done), 0);
    checkOutput("b2b_busy", int'(busy), 1);
    start = 1'b0;
    trackRun(2, 0, 0, 10'h000, firstD, aborted);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
